// File: rtl/lcd1602_bus_sched.sv
// LCD1602 write-bus scheduler: power-up init, round-robin arbitration of two requesters, EN timing.
// Optional LCD_CLR_WAIT_EN: insert an extra idle wait after clear (0x01) / home (0x02) commands.
module lcd1602_bus_sched #(
    parameter int unsigned PWRUP_CYC    = 750000,
    parameter int unsigned EN_HALF_CYC  = 50000,
    parameter int unsigned CLR_WAIT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam int unsigned MAX_A   = (PWRUP_CYC > EN_HALF_CYC) ? PWRUP_CYC : EN_HALF_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > CLR_WAIT_CYC) ? MAX_A : CLR_WAIT_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] EN_LAST    = CW'(EN_HALF_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_WAIT_CYC - 1);

    localparam logic [2:0] S_PWRUP     = 3'd0;
    localparam logic [2:0] S_INIT_LOAD = 3'd1;
    localparam logic [2:0] S_SETUP     = 3'd2;
    localparam logic [2:0] S_PULSE     = 3'd3;
    localparam logic [2:0] S_WAIT      = 3'd4;
    localparam logic [2:0] S_IDLE      = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          en_q;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          init_done_q, init_done_d;
    logic          prio_q, prio_d;  // requester preferred on a tie
    logic          xfer_done;

`ifdef LCD_CLR_WAIT_EN
    logic is_clr;
    assign is_clr = !rs_q && (data_q == 8'h01 || data_q == 8'h02);
`endif

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    init_byte = 8'h38;
            3'd1:    init_byte = 8'h08;
            3'd2:    init_byte = 8'h01;
            3'd3:    init_byte = 8'h06;
            default: init_byte = 8'h0C;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rs_d        = rs_q;
        data_d      = data_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        init_done_d = init_done_q;
        prio_d      = prio_q;
        xfer_done   = 1'b0;

        case (state_q)
            S_PWRUP: if (cnt_q == PWRUP_LAST) state_d = S_INIT_LOAD;
            S_INIT_LOAD: begin
                rs_d    = 1'b0;
                data_d  = init_byte(idx_q);
                state_d = S_SETUP;
            end
            S_SETUP: if (cnt_q == EN_LAST) state_d = S_PULSE;
            S_PULSE: begin
                if (cnt_q == EN_LAST) begin
`ifdef LCD_CLR_WAIT_EN
                    if (is_clr) state_d = S_WAIT;
                    else        xfer_done = 1'b1;
`else
                    xfer_done = 1'b1;
`endif
                end
            end
            S_WAIT: if (cnt_q == CLR_LAST) xfer_done = 1'b1;
            S_IDLE: begin
                if (req0 && (!req1 || !prio_q)) begin
                    rs_d    = rs0;
                    data_d  = data0;
                    ack0_d  = 1'b1;
                    prio_d  = 1'b1;
                    state_d = S_SETUP;
                end else if (req1) begin
                    rs_d    = rs1;
                    data_d  = data1;
                    ack1_d  = 1'b1;
                    prio_d  = 1'b0;
                    state_d = S_SETUP;
                end
            end
            default: state_d = S_PWRUP;
        endcase

        // End of a transfer: either advance the init table or return to arbitration.
        if (xfer_done) begin
            if (init_done_q) begin
                state_d = S_IDLE;
            end else if (idx_q == 3'd4) begin
                state_d     = S_IDLE;
                init_done_d = 1'b1;
            end else begin
                idx_d   = idx_q + 3'd1;
                state_d = S_INIT_LOAD;
            end
        end

        cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_PWRUP;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            en_q        <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            init_done_q <= 1'b0;
            prio_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            en_q        <= (state_d == S_PULSE);
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            init_done_q <= init_done_d;
            prio_q      <= prio_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign init_done = init_done_q;
    assign busy      = (state_q != S_IDLE);
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = en_q;
    assign lcd_data  = data_q;

endmodule

// File: tb/tb_lcd1602_bus_sched.sv
// Directed bench for lcd1602_bus_sched: init sequence, arbitration vectors, clear wait, reset abort.
module tb_lcd1602_bus_sched;

    localparam int PWRUP = 20;
    localparam int EN    = 4;
    localparam int CLRW  = 10;
`ifdef LCD_CLR_WAIT_EN
    localparam int CLRX = CLRW;
`else
    localparam int CLRX = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, rs0, req1, rs1;
    logic [7:0] data0, data1;
    logic       ack0, ack1, init_done, busy, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    lcd1602_bus_sched #(
        .PWRUP_CYC   (PWRUP),
        .EN_HALF_CYC (EN),
        .CLR_WAIT_CYC(CLRW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .rs0      (rs0),
        .data0    (data0),
        .ack0     (ack0),
        .req1     (req1),
        .rs1      (rs1),
        .data1    (data1),
        .ack1     (ack1),
        .init_done(init_done),
        .busy     (busy),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_data (lcd_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Bus monitor, sampled on the falling clock edge.
    logic [8:0] fall_q [$];
    logic [8:0] hist [0:8];
    int hist_n = 0, hi_cnt = 0;
    int rw_bad = 0, stab_bad = 0, width_bad = 0, ack_bad = 0;
    logic prev_en = 1'b0, prev_ack0 = 1'b0, prev_ack1 = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (lcd_rw !== 1'b0) rw_bad++;
            if (!rst_n) begin
                hist_n = 0; hi_cnt = 0;
                prev_en = 1'b0; prev_ack0 = 1'b0; prev_ack1 = 1'b0;
            end else begin
                if ((ack0 && prev_ack0) || (ack1 && prev_ack1)) ack_bad++;
                if ((ack0 || ack1) && !init_done) ack_bad++;
                for (int i = 8; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = {lcd_rs, lcd_data};
                if (hist_n < 9) hist_n++;
                if (lcd_en) begin
                    hi_cnt++;
                end else if (prev_en) begin
                    // hold cycle: SETUP, PULSE and this cycle must all show the same byte
                    if (hi_cnt != EN) width_bad++;
                    if (hist_n < 9) stab_bad++;
                    for (int i = 1; i < 9; i++) if (hist[i] !== hist[0]) stab_bad++;
                    fall_q.push_back(hist[1]);
                    hi_cnt = 0;
                end
                prev_en = lcd_en; prev_ack0 = ack0; prev_ack1 = ack1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int got_fall(input int i);
        if (i < fall_q.size()) return int'(fall_q[i]);
        return 'h3ff;
    endfunction

    task automatic wait_idle(input string name);
        int c = 0;
        while (busy !== 1'b0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) check(name, 1, 0);
    endtask

    task automatic wait_falls(input int n, input string name);
        int c = 0;
        while (fall_q.size() < n && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (c >= 100) check(name, fall_q.size(), n);
    endtask

    typedef struct {
        logic       r0;
        logic       rs0;
        logic [7:0] d0;
        logic       r1;
        logic       rs1;
        logic [7:0] d1;
        logic       g1;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs [6];
    logic [7:0] init_tab [5];

    int first_en, done_n, ack_n, base, c, bn, found;
    logic ack_rs, a0, a1;
    logic [7:0] ack_data;
    int order [4];
    int ack_cyc [4];

    initial begin
        init_tab = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        // Round-robin trace: the init-time grant went to req0, so req1 is preferred first.
        vecs[0] = '{1'b1, 1'b1, 8'h41, 1'b1, 1'b1, 8'h42, 1'b1, 9'h142};
        vecs[1] = '{1'b1, 1'b0, 8'h43, 1'b1, 1'b1, 8'h44, 1'b0, 9'h043};
        vecs[2] = '{1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 8'h80, 1'b1, 9'h080};
        vecs[3] = '{1'b1, 1'b1, 8'hC5, 1'b1, 1'b1, 8'h3C, 1'b0, 9'h1C5};
        vecs[4] = '{1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h11, 1'b0, 9'h15A};
        vecs[5] = '{1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 8'hE7, 1'b1, 9'h0E7};

        rst_n = 1'b0;
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h55;
        req1 = 1'b0; rs1 = 1'b0; data1 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_lcd_en", lcd_en, 0);
        check("rst_busy", busy, 1);
        check("rst_init_done", init_done, 0);
        check("rst_acks", {ack0, ack1}, 0);
        check("rst_bus", {lcd_rs, lcd_data}, 0);
        rst_n = 1'b1;

        // Power-up, init sequence, and req0 held from reset release.
        first_en = -1; done_n = -1; ack_n = -1; ack_rs = 1'b0; ack_data = 8'h00;
        for (int k = 1; k <= 300 && ack_n < 0; k++) begin
            @(negedge clk);
            if (lcd_en && first_en < 0) first_en = k;
            if (init_done && done_n < 0) done_n = k;
            if (ack0 && ack_n < 0) begin
                ack_n = k; ack_rs = lcd_rs; ack_data = lcd_data; req0 = 1'b0;
            end
        end
        req0 = 1'b0;
        check("first_en_cycle", first_en, PWRUP + 1 + EN);
        check("init_done_cycle", done_n, PWRUP + 5 * (1 + 2 * EN) + CLRX);
        check("ack0_after_init", ack_n, done_n + 1);
        check("ack0_bus", {ack_rs, ack_data}, 9'h155);
        wait_falls(6, "init_falls_timeout");
        for (int i = 0; i < 5; i++)
            check($sformatf("init_byte%0d", i), got_fall(i), {1'b0, init_tab[i]});
        check("req0_byte", got_fall(5), 9'h155);

        // Table-driven arbitration vectors.
        for (int v = 0; v < 6; v++) begin
            wait_idle($sformatf("vec%0d_idle_timeout", v));
            base = fall_q.size();
            @(negedge clk);
            req0 = vecs[v].r0; rs0 = vecs[v].rs0; data0 = vecs[v].d0;
            req1 = vecs[v].r1; rs1 = vecs[v].rs1; data1 = vecs[v].d1;
            a0 = 1'b0; a1 = 1'b0; c = 0;
            while (!(a0 || a1) && c < 20) begin
                @(negedge clk);
                a0 = ack0; a1 = ack1; c++;
            end
            req0 = 1'b0; req1 = 1'b0;
            check($sformatf("vec%0d_ack0", v), a0, !vecs[v].g1);
            check($sformatf("vec%0d_ack1", v), a1, vecs[v].g1);
            wait_falls(base + 1, $sformatf("vec%0d_fall_timeout", v));
            check($sformatf("vec%0d_byte", v), got_fall(base), vecs[v].exp);
        end

        // Both requesters held: grants alternate 0,1,0,1, back to back.
        wait_idle("rr_idle_timeout");
        base = fall_q.size();
        @(negedge clk);
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h42;
        found = 0;
        for (int k = 1; k <= 100 && found < 4; k++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                order[found] = ack1 ? 1 : 0;
                ack_cyc[found] = k;
                if (ack0) data0 = 8'h43;
                if (ack1) data1 = 8'h44;
                found++;
                if (found == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr_grant_count", found, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < found) check($sformatf("rr_order%0d", k), order[k], k % 2);
            if (k > 0 && k < found)
                check($sformatf("rr_gap%0d", k), ack_cyc[k] - ack_cyc[k-1], 2 * EN + 1);
        end
        wait_falls(base + 4, "rr_fall_timeout");
        for (int k = 0; k < 4; k++)
            check($sformatf("rr_byte%0d", k), got_fall(base + k), 9'h141 + k);

        // Clear command from req1 while req0 waits.
        wait_idle("clr_idle_timeout");
        base = fall_q.size();
        @(negedge clk);
        req1 = 1'b1; rs1 = 1'b0; data1 = 8'h01;
        c = 0;
        while (!ack1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        req1 = 1'b0;
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h77;
        check("clr_ack1_seen", ack1, 1);
        bn = 1; c = 0;
        while (c < 60) begin
            @(negedge clk);
            c++;
            if (busy) bn++;
            else break;
        end
        check("clr_busy_len", bn, 2 * EN + CLRX);
        @(negedge clk);
        check("clr_ack0_next", ack0, 1);
        req0 = 1'b0;
        wait_falls(base + 2, "clr_fall_timeout");
        check("clr_byte", got_fall(base), 9'h001);
        check("clr_next_byte", got_fall(base + 1), 9'h177);

        // Reset while EN is high.
        wait_idle("rst_idle_timeout");
        @(negedge clk);
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h99;
        c = 0;
        while (!lcd_en && c < 30) begin
            @(negedge clk);
            if (ack0) req0 = 1'b0;
            c++;
        end
        req0 = 1'b0;
        check("abort_en_seen", lcd_en, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_lcd_en", lcd_en, 0);
        check("abort_init_done", init_done, 0);
        check("abort_busy", busy, 1);
        rst_n = 1'b1;
        base = fall_q.size();
        first_en = -1;
        for (int k = 1; k <= 60 && first_en < 0; k++) begin
            @(negedge clk);
            if (lcd_en) first_en = k;
        end
        check("restart_first_en", first_en, PWRUP + 1 + EN);
        wait_falls(base + 1, "restart_fall_timeout");
        check("restart_byte0", got_fall(base), 9'h038);
        check("restart_init_done", init_done, 0);

        check("lcd_rw_zero", rw_bad, 0);
        check("bus_stable", stab_bad, 0);
        check("en_width", width_bad, 0);
        check("ack_pulses", ack_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
